// File: rtl/fft2048_pkg.sv
// Shared sizes, FSM encoding and address helpers for the 2048-point FFT.
package fft2048_pkg;

    localparam int N      = 2048;
    localparam int LOGN   = 11;
    localparam int DW_IN  = 8;
    localparam int DW_ACC = 41;
    localparam int AW     = LOGN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [AW-1:0] bitrev11(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft2048_core_sram.sv
// Single-write, multi-async-read RAM; contents survive reset.
module fft_sram
    import fft2048_pkg::*;
#(
    parameter int WIDTH = DW_ACC,
    parameter int DEPTH = N,
    parameter int NRD   = 2,
    parameter int RAW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [RAW-1:0]          waddr,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic [RAW-1:0]          raddr [NRD],
    output logic signed [WIDTH-1:0] rdata [NRD]
);

    logic signed [WIDTH-1:0] memory [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) memory[waddr] <= wdata;
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) rdata[i] = memory[raddr[i]];
    end

endmodule

// File: rtl/fft2048_core.sv
// In-place radix-2 DIT FFT: serial load, 4-cycle butterfly engine,
// natural-order result streamed once after the last stage.
module fft2048_core
    import fft2048_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW_IN-1:0]         data_in_r,
    input  logic [DW_IN-1:0]         data_in_i,
    input  logic [DW_IN-1:0]         data_w_r,
    input  logic [DW_IN-1:0]         data_w_i,
    output logic signed [DW_ACC-1:0] data_out_r,
    output logic signed [DW_ACC-1:0] data_out_i,
    output logic [1:0]               state
);

    localparam int PW = DW_ACC + DW_IN + 1;

    state_t                   state_q, state_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic [3:0]               stg_q, stg_d;
    logic [AW-2:0]            bf_q, bf_d;
    logic [1:0]               ph_q, ph_d;
    logic signed [DW_ACC-1:0] xpr_q, xpr_d, xpi_q, xpi_d;
    logic signed [DW_ACC-1:0] xqr_q, xqr_d, xqi_q, xqi_d;
    logic signed [DW_ACC-1:0] tr_q, tr_d, ti_q, ti_d;
    logic signed [DW_ACC-1:0] dor_q, dor_d, doi_q, doi_d;

    logic [AW-1:0]            mask, kk, pa, qa, ta;
    logic [AW-1:0]            ram_ra [2];
    logic signed [DW_ACC-1:0] rd_r [2];
    logic signed [DW_ACC-1:0] rd_i [2];
    logic                     ram_we;
    logic [AW-1:0]            ram_wa;
    logic signed [DW_ACC-1:0] wd_r, wd_i;
    logic                     tw_we;
    logic [AW-1:0]            tw_ra [1];
    logic signed [DW_IN-1:0]  tw_r [1];
    logic signed [DW_IN-1:0]  tw_i [1];
    logic signed [PW-1:0]     prod_r, prod_i;

    // p is the butterfly index with a zero inserted at bit s
    always_comb begin
        mask      = (AW'(1) << stg_q) - AW'(1);
        kk        = {1'b0, bf_q} & mask;
        pa        = (({1'b0, bf_q} & ~mask) << 1) | kk;
        qa        = pa | (mask + AW'(1));
        ta        = mask + kk;
        ram_ra[0] = (state_q == S_DONE) ? cnt_q[AW-1:0] : pa;
        ram_ra[1] = qa;
        tw_ra[0]  = ta;
    end

    always_comb begin
        prod_r = PW'(tw_r[0]) * PW'(xqr_q) - PW'(tw_i[0]) * PW'(xqi_q);
        prod_i = PW'(tw_r[0]) * PW'(xqi_q) + PW'(tw_i[0]) * PW'(xqr_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        bf_d    = bf_q;
        ph_d    = ph_q;
        xpr_d   = xpr_q;
        xpi_d   = xpi_q;
        xqr_d   = xqr_q;
        xqi_d   = xqi_q;
        tr_d    = tr_q;
        ti_d    = ti_q;
        dor_d   = dor_q;
        doi_d   = doi_q;
        ram_we  = 1'b0;
        ram_wa  = pa;
        wd_r    = '0;
        wd_i    = '0;
        tw_we   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                ram_we = 1'b1;
                ram_wa = bitrev11(cnt_q[AW-1:0]);
                wd_r   = {{(DW_ACC-DW_IN){data_in_r[DW_IN-1]}}, data_in_r};
                wd_i   = {{(DW_ACC-DW_IN){data_in_i[DW_IN-1]}}, data_in_i};
                tw_we  = (cnt_q[AW-1:0] != {AW{1'b1}});
                cnt_d  = cnt_q + (AW+1)'(1);
                if (cnt_q[AW-1:0] == {AW{1'b1}}) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                ph_d = ph_q + 2'd1;
                unique case (ph_q)
                    2'd0: begin
                        xpr_d = rd_r[0];
                        xpi_d = rd_i[0];
                        xqr_d = rd_r[1];
                        xqi_d = rd_i[1];
                    end
                    2'd1: begin
                        tr_d = DW_ACC'((prod_r + PW'(64)) >>> 7);
                        ti_d = DW_ACC'((prod_i + PW'(64)) >>> 7);
                    end
                    2'd2: begin
                        ram_we = 1'b1;
                        ram_wa = pa;
                        wd_r   = xpr_q + tr_q;
                        wd_i   = xpi_q + ti_q;
                    end
                    2'd3: begin
                        ram_we = 1'b1;
                        ram_wa = qa;
                        wd_r   = xpr_q - tr_q;
                        wd_i   = xpi_q - ti_q;
                        bf_d   = bf_q + (AW-1)'(1);
                        if (bf_q == {(AW-1){1'b1}}) begin
                            if (stg_q == 4'(LOGN-1)) state_d = S_DONE;
                            else stg_d = stg_q + 4'd1;
                        end
                    end
                endcase
            end
            S_DONE: begin
                if (!cnt_q[AW]) begin
                    dor_d = rd_r[0];
                    doi_d = rd_i[0];
                    cnt_d = cnt_q + (AW+1)'(1);
                end else begin
                    dor_d = '0;
                    doi_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
            bf_q    <= '0;
            ph_q    <= '0;
            xpr_q   <= '0;
            xpi_q   <= '0;
            xqr_q   <= '0;
            xqi_q   <= '0;
            tr_q    <= '0;
            ti_q    <= '0;
            dor_q   <= '0;
            doi_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            bf_q    <= bf_d;
            ph_q    <= ph_d;
            xpr_q   <= xpr_d;
            xpi_q   <= xpi_d;
            xqr_q   <= xqr_d;
            xqi_q   <= xqi_d;
            tr_q    <= tr_d;
            ti_q    <= ti_d;
            dor_q   <= dor_d;
            doi_q   <= doi_d;
        end
    end

    fft_sram #(.WIDTH(DW_ACC), .DEPTH(N), .NRD(2)) sram1_r (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_wa),
        .wdata (wd_r),
        .raddr (ram_ra),
        .rdata (rd_r)
    );

    fft_sram #(.WIDTH(DW_ACC), .DEPTH(N), .NRD(2)) sram1_i (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_wa),
        .wdata (wd_i),
        .raddr (ram_ra),
        .rdata (rd_i)
    );

    fft_sram #(.WIDTH(DW_IN), .DEPTH(N), .NRD(1)) sram_wr (
        .clk   (clk),
        .we    (tw_we),
        .waddr (cnt_q[AW-1:0]),
        .wdata ($signed(data_w_r)),
        .raddr (tw_ra),
        .rdata (tw_r)
    );

    fft_sram #(.WIDTH(DW_IN), .DEPTH(N), .NRD(1)) sram_wi (
        .clk   (clk),
        .we    (tw_we),
        .waddr (cnt_q[AW-1:0]),
        .wdata ($signed(data_w_i)),
        .raddr (tw_ra),
        .rdata (tw_i)
    );

    assign data_out_r = dor_q;
    assign data_out_i = doi_q;
    assign state      = state_q;

endmodule

// File: tb/tb_fft2048_core.sv
// Bench for fft2048_core: aborted run, then x = 100, 64, 32 at n = 0, 1, 2.
module tb_fft2048_core;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         din_r, din_i, dw_r, dw_i;
    logic signed [40:0] dout_r, dout_i;
    logic [1:0]         state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int bin;
        int er;
        int ei;
    } vec_t;

    vec_t tbl [8];

    fft2048_core dut (
        .clk        (clk),
        .rst        (rst),
        .data_in_r  (din_r),
        .data_in_i  (din_i),
        .data_w_r   (dw_r),
        .data_w_i   (dw_i),
        .data_out_r (dout_r),
        .data_out_i (dout_i),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    endfunction

    function automatic int sample(input int n);
        return (n == 0) ? 100 : (n == 1) ? 64 : (n == 2) ? 32 : 0;
    endfunction

    function automatic void twid(input int n, output logic [7:0] wr,
                                 output logic [7:0] wi);
        int  s = 0;
        int  k;
        real a;
        while (((1 << (s + 1)) - 1) <= n) s++;
        k  = n - ((1 << s) - 1);
        a  = 2.0 * PI * k / real'(1 << (s + 1));
        wr = 8'(rnd(127.0 * $cos(a)));
        wi = 8'(rnd(-127.0 * $sin(a)));
    endfunction

    function automatic int exp_re(input int m);
        real th = 2.0 * PI * m / 2048.0;
        return rnd(100.0 + 64.0 * $cos(th) + 32.0 * $cos(2.0 * th));
    endfunction

    function automatic int exp_im(input int m);
        real th = 2.0 * PI * m / 2048.0;
        return rnd(-64.0 * $sin(th) - 32.0 * $sin(2.0 * th));
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d",
                     name, act, exp, tol);
        end
    endtask

    task automatic garbage();
        din_r = 8'($urandom);
        din_i = 8'($urandom);
        dw_r  = 8'($urandom);
        dw_i  = 8'($urandom);
    endtask

    task automatic load(input bit golden);
        for (int n = 0; n < 2048; n++) begin
            if (golden) begin
                din_r = 8'(sample(n));
                din_i = 8'd0;
                twid(n, dw_r, dw_i);
            end else begin
                garbage();
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0,    196,   0};
        tbl[1] = '{1024,  68,   0};
        tbl[2] = '{512,   68, -63};
        tbl[3] = '{1536,  68,  63};
        tbl[4] = '{256,  145, -77};
        tbl[5] = '{1280,  55,  13};
        tbl[6] = '{768,   55, -13};
        tbl[7] = '{1792, 145,  77};

        rst = 1'b0;
        garbage();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0, 0);
        chk("rst_out_r", dout_r, 0, 0);
        chk("rst_out_i", dout_i, 0, 0);

        // run that is cut short in the middle of CALC
        rst = 1'b1;
        @(posedge clk);
        #1;
        load(1'b0);
        repeat (300) begin
            garbage();
            @(posedge clk);
        end
        #1;
        chk("abort_in_calc", state, 2, 0);
        rst = 1'b0;
        #1;
        chk("abort_state", state, 0, 0);
        chk("abort_out_r", dout_r, 0, 0);
        chk("abort_out_i", dout_i, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_hold", state, 0, 0);

        // full run
        rst = 1'b1;
        #1;
        chk("idle_cycle", state, 0, 0);
        @(posedge clk);
        #1;
        chk("load_entry", state, 1, 0);
        load(1'b1);
        chk("calc_entry", state, 2, 0);
        for (int i = 0; i < 45055; i++) begin
            garbage();
            @(posedge clk);
        end
        #1;
        chk("calc_last", state, 2, 0);
        @(posedge clk);
        #1;
        chk("done_entry", state, 3, 0);
        chk("done_out0", dout_r, 0, 0);

        for (int m = 0; m < 2048; m++) begin
            garbage();
            @(posedge clk);
            #1;
            chk($sformatf("stream_r[%0d]", m), dout_r, exp_re(m), 3);
            chk($sformatf("stream_i[%0d]", m), dout_i, exp_im(m), 3);
        end
        @(posedge clk);
        #1;
        chk("tail_r", dout_r, 0, 0);
        chk("tail_i", dout_i, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_state", state, 3, 0);
        chk("hold_r", dout_r, 0, 0);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mem_r[%0d]", tbl[i].bin),
                dut.sram1_r.memory[tbl[i].bin], tbl[i].er, 0);
            chk($sformatf("mem_i[%0d]", tbl[i].bin),
                dut.sram1_i.memory[tbl[i].bin], tbl[i].ei, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
